// File: rtl/psum_accumulator.sv
// Packet accumulator for signed partial products, using the truncating approximate add.
// Define SATURATE_EN to clamp on signed overflow and report it on out_ovf; otherwise the sum wraps.
module psum_accumulator #(
  parameter int IN_W       = 16,
  parameter int ACC_W      = 24,
  parameter int IGNORE_BIT = 0,
  parameter int MAX_LEN    = 256,
  localparam int CNT_W     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_len,
  output logic             out_err,
  output logic             out_ovf
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_OUT} state_t;

  localparam logic [ACC_W-1:0] LSB_MASK = ~({ACC_W{1'b1}} << IGNORE_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pkt_ovf;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_data;
  logic [CNT_W-1:0]   r_out_len;
  logic               r_out_err;
  logic               r_out_ovf;

  logic               w_idle;
  logic               w_beat;
  logic [ACC_W-1:0]   w_a;
  logic [ACC_W-1:0]   w_b;
  logic [ACC_W-1:0]   w_af;
  logic [ACC_W-1:0]   w_bf;
  logic [ACC_W-1:0]   w_sum;
  logic [ACC_W-1:0]   w_next;
  logic               w_add_ovf;
  logic               w_pkt_ovf;
  logic [CNT_W-1:0]   w_cnt_base;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_close;

  assign w_idle = (r_state == ST_IDLE);
  assign w_beat = in_valid && r_in_ready;

  // First beat of a packet adds onto a zero operand, which still gets its LSBs forced high.
  assign w_a   = w_idle ? '0 : r_acc;
  assign w_b   = ACC_W'($signed(in_data));
  assign w_af  = w_a | LSB_MASK;
  assign w_bf  = w_b & ~LSB_MASK;
  assign w_sum = w_af + w_bf;

`ifdef SATURATE_EN
  assign w_add_ovf = (w_af[ACC_W-1] == w_bf[ACC_W-1]) && (w_sum[ACC_W-1] != w_af[ACC_W-1]);
  assign w_next    = !w_add_ovf     ? w_sum :
                     w_af[ACC_W-1]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                      {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign w_add_ovf = 1'b0;
  assign w_next    = w_sum;
`endif

  assign w_pkt_ovf  = (!w_idle && r_pkt_ovf) || w_add_ovf;
  assign w_cnt_base = w_idle ? '0 : r_cnt;
  assign w_cnt_nxt  = w_cnt_base + CNT_W'(1);
  assign w_close    = in_last || (w_cnt_base == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_pkt_ovf   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_len   <= '0;
      r_out_err   <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACC: begin
          if (w_beat) begin
            r_acc     <= w_next;
            r_cnt     <= w_cnt_nxt;
            r_pkt_ovf <= w_pkt_ovf;
            if (w_close) begin
              r_state     <= ST_OUT;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_data  <= w_next;
              r_out_len   <= w_cnt_nxt;
              r_out_err   <= !in_last;
              r_out_ovf   <= w_pkt_ovf;
            end else begin
              r_state <= ST_ACC;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_pkt_ovf   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_len   <= '0;
            r_out_err   <= 1'b0;
            r_out_ovf   <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_len   = r_out_len;
  assign out_err   = r_out_err;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: two instances (default, and ACC_W=16/IGNORE_BIT=2/MAX_LEN=4),
// each checked every cycle against a packet-level model, plus directed literal cases.
module tb_psum_accumulator;

`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v0 = 0, l0 = 0, ordy0 = 1;
  logic [15:0] d0 = '0;
  logic        rdy0, ov0, err0, ovf0;
  logic [23:0] od0;
  logic [8:0]  len0;

  logic        v1 = 0, l1 = 0, ordy1 = 1;
  logic [15:0] d1 = '0;
  logic        rdy1, ov1, err1, ovf1;
  logic [15:0] od1;
  logic [2:0]  len1;

  psum_accumulator u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_data(d0), .in_last(l0),
    .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .out_len(len0), .out_err(err0), .out_ovf(ovf0)
  );

  psum_accumulator #(.IN_W(16), .ACC_W(16), .IGNORE_BIT(2), .MAX_LEN(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1), .in_last(l1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_len(len1), .out_err(err1), .out_ovf(ovf1)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Packet sum straight from the arithmetic rule: force LSBs, add as integers, clamp or wrap.
  function automatic longint fold(input longint q[$], input int accw, input int ig, output bit ovf);
    longint acc = 0;
    longint hi  = (longint'(1) << (accw - 1)) - 1;
    longint lo  = -(longint'(1) << (accw - 1));
    longint m   = (longint'(1) << ig) - 1;
    longint s;
    ovf = 1'b0;
    foreach (q[i]) begin
      s = (acc | m) + (q[i] & ~m);
      if (s > hi || s < lo) begin
        ovf = 1'b1;
        if (SAT) s = (s > hi) ? hi : lo;
        else begin
          s = s & ((longint'(1) << accw) - 1);
          if (s > hi) s = s - (longint'(1) << accw);
        end
      end
      acc = s;
    end
    return acc;
  endfunction

  longint q0[$], q1[$];
  bit     busy0 = 0, busy1 = 0;
  longint e_d0 = 0, e_d1 = 0;
  int     e_len0 = 0, e_len1 = 0;
  bit     e_err0 = 0, e_err1 = 0, e_ovf0 = 0, e_ovf1 = 0;

  always @(posedge clk) begin : model0
    bit o;
    if (!rst_n) begin
      q0.delete(); busy0 = 0; e_d0 = 0; e_len0 = 0; e_err0 = 0; e_ovf0 = 0;
    end else if (busy0) begin
      if (ordy0) begin busy0 = 0; e_d0 = 0; e_len0 = 0; e_err0 = 0; e_ovf0 = 0; end
    end else if (v0) begin
      q0.push_back(longint'($signed(d0)));
      if (l0 || q0.size() == 256) begin
        e_d0 = fold(q0, 24, 0, o); e_ovf0 = SAT && o;
        e_len0 = q0.size(); e_err0 = !l0; busy0 = 1; q0.delete();
      end
    end
  end

  always @(posedge clk) begin : model1
    bit o;
    if (!rst_n) begin
      q1.delete(); busy1 = 0; e_d1 = 0; e_len1 = 0; e_err1 = 0; e_ovf1 = 0;
    end else if (busy1) begin
      if (ordy1) begin busy1 = 0; e_d1 = 0; e_len1 = 0; e_err1 = 0; e_ovf1 = 0; end
    end else if (v1) begin
      q1.push_back(longint'($signed(d1)));
      if (l1 || q1.size() == 4) begin
        e_d1 = fold(q1, 16, 2, o); e_ovf1 = SAT && o;
        e_len1 = q1.size(); e_err1 = !l1; busy1 = 1; q1.delete();
      end
    end
  end

  always @(negedge clk) begin : compare
    bit b0, b1;
    b0 = rst_n && busy0;
    b1 = rst_n && busy1;
    chk("u0 in_ready",  rdy0, !b0);
    chk("u0 out_valid", ov0,  b0);
    chk("u0 out_data",  longint'($signed(od0)), b0 ? e_d0 : 0);
    chk("u0 out_len",   len0, b0 ? e_len0 : 0);
    chk("u0 out_err",   err0, b0 ? e_err0 : 0);
    chk("u0 out_ovf",   ovf0, b0 ? e_ovf0 : 0);
    chk("u1 in_ready",  rdy1, !b1);
    chk("u1 out_valid", ov1,  b1);
    chk("u1 out_data",  longint'($signed(od1)), b1 ? e_d1 : 0);
    chk("u1 out_len",   len1, b1 ? e_len1 : 0);
    chk("u1 out_err",   err1, b1 ? e_err1 : 0);
    chk("u1 out_ovf",   ovf1, b1 ? e_ovf1 : 0);
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send0(input int d, input bit last);
    bit ok = 0;
    v0 = 1; d0 = 16'(d); l0 = last;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); ok = rdy0; @(posedge clk);
      if (ok) break;
    end
    #1 v0 = 0; l0 = 0;
    chk("u0 beat accepted", ok, 1);
  endtask

  task automatic send1(input int d, input bit last);
    bit ok = 0;
    v1 = 1; d1 = 16'(d); l1 = last;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); ok = rdy1; @(posedge clk);
      if (ok) break;
    end
    #1 v1 = 0; l1 = 0;
    chk("u1 beat accepted", ok, 1);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("reset in_ready", rdy0, 1);
    chk("reset out_data", od0, 0);
    step();

    send0(3, 0); send0(-5, 0); send0(10, 1);
    @(negedge clk);
    chk("basic out_valid", ov0, 1);
    chk("basic out_data", longint'($signed(od0)), 8);
    chk("basic out_len", len0, 3);
    chk("basic out_err", err0, 0);
    step();
    @(negedge clk);
    chk("basic back to idle", rdy0, 1);
    step();

    send1(5, 0); send1(6, 1);
    @(negedge clk);
    chk("ignore2 out_data", longint'($signed(od1)), 11);
    chk("ignore2 out_len", len1, 2);
    step();

    ordy0 = 0;
    send0(1, 0); send0(2, 1);
    v0 = 1; d0 = 16'd99; l0 = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold out_data", longint'($signed(od0)), 3);
      chk("hold in_ready", rdy0, 0);
      step();
    end
    ordy0 = 1; v0 = 0; l0 = 0;
    step();
    @(negedge clk);
    chk("release out_valid", ov0, 0);
    chk("release in_ready", rdy0, 1);
    step();

    repeat (4) send1(1, 0);
    @(negedge clk);
    chk("maxlen out_data", longint'($signed(od1)), 3);
    chk("maxlen out_len", len1, 4);
    chk("maxlen out_err", err1, 1);
    step();
    send1(1, 1);
    @(negedge clk);
    chk("new pkt out_len", len1, 1);
    chk("new pkt out_err", err1, 0);
    step();

    send1(32767, 0); send1(4, 1);
    @(negedge clk);
    chk("overflow out_data", longint'($signed(od1)), SAT ? 32767 : -32765);
    chk("overflow out_ovf", ovf1, SAT ? 1 : 0);
    step();

    send0(1, 0); send0(2, 0);
    rst_n = 0;
    @(negedge clk);
    chk("midreset in_ready", rdy0, 1);
    chk("midreset out_valid", ov0, 0);
    step();
    rst_n = 1;
    send0(7, 1);
    @(negedge clk);
    chk("after reset out_data", longint'($signed(od0)), 7);
    chk("after reset out_len", len0, 1);
    step();

    fork
      for (int i = 0; i < 1500; i++) begin
        v0 = ($urandom_range(0, 9) < 7);
        d0 = 16'($urandom);
        l0 = ($urandom_range(0, 3) == 0);
        ordy0 = ($urandom_range(0, 2) != 0);
        rst_n = !(i % 500 == 250);
        step();
      end
      for (int i = 0; i < 1500; i++) begin
        v1 = ($urandom_range(0, 9) < 7);
        d1 = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
        l1 = ($urandom_range(0, 5) == 0);
        ordy1 = ($urandom_range(0, 2) != 0);
        step();
      end
    join
    rst_n = 1; v0 = 0; v1 = 0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
